rf_wb_arbiter: RTL

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 18 +
 rtl/rf_wb_arbiter_rr.sv | 46 ++++
 rtl/rf_wb_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared core constants for the writeback path: default datapath/register-file
// sizing and the encoding used to remember which requester was granted last.
package rf_wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } gnt_e;

    // Bit positions of each requester inside the arbiter req/gnt vectors.
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Two-way round-robin arbiter: a lone requester wins immediately, a tie goes to
// whichever requester was not granted most recently.
module rr_arb2
    import rf_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    gnt_e last_grant_q;
    gnt_e last_grant_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_grant_q == GNT_ALU) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt[REQ_MEM]) begin
            last_grant_d = GNT_MEM;
        end else if (gnt[REQ_ALU]) begin
            last_grant_d = GNT_ALU;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GNT_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: shares one write port between the ALU and
// load paths, tracks long-latency destinations pending, and filters x0 writes.
module rf_wb_arbiter #(
    parameter  int XLEN = rf_wb_arbiter_pkg::XLEN,
    parameter  int NREG = rf_wb_arbiter_pkg::NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,

    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,

    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,

    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,

    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    import rf_wb_arbiter_pkg::*;

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            alu_gnt;
    logic            mem_gnt;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    logic            rf_we_q,    rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    assign req[REQ_ALU] = alu_valid;
    assign req[REQ_MEM] = mem_valid;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    assign alu_gnt   = gnt[REQ_ALU];
    assign mem_gnt   = gnt[REQ_MEM];
    assign alu_ready = alu_gnt;
    assign mem_ready = mem_gnt;

    assign win_rd   = mem_gnt ? mem_rd   : alu_rd;
    assign win_data = mem_gnt ? mem_data : alu_data;

    // A granted write to x0 still completes the handshake but never reaches the file.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if ((alu_gnt || mem_gnt) && (win_rd != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = win_rd;
            rf_wdata_d = win_data;
        end
    end

    // Set is applied after clear so a newly issued op keeps ownership of its register.
    always_comb begin
        pending_d = pending_q;
        if (mem_gnt) begin
            pending_d[mem_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            pending_q  <= pending_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Masking with reset drops a write that was in flight when reset arrived.
    assign rf_we    = rf_we_q & ~reset;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    assign rs1_busy = pending_q[rs1_addr];
    assign rs2_busy = pending_q[rs2_addr];

endmodule
